imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Sequences program loading into the instruction memory from a host word stream, then releases the CPU core from reset.
- Sits between the host/test harness and the instruction-memory RAM write port.
- Owns the core's active-low reset input for the whole load sequence.
- Replaces behavioural memory preloading with a synthesizable valid/ready load path and a deterministic reset-release sequence.

Parameters:
- ADDR_W, 32, width of instruction-memory addresses and of word_count/base_addr.
- DATA_W, 32, instruction word width.
- MEM_WORDS, 256, instruction-memory capacity in words; larger loads are rejected.
- ADDR_STEP, 1, address increment per loaded word (1 = word-addressed RAM).
- RESET_HOLD, 4, cycles core_reset_n stays low after the final write; must be >= 1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled in IDLE or RUN.
- abort  in  1  cancels an in-progress load.
- base_addr  in  ADDR_W  first write address; latched on an accepted start.
- word_count  in  ADDR_W  number of words to load; latched on an accepted start.
- host_valid  in  1  host_data holds a valid word.
- host_data  in  DATA_W  program word.
- host_ready  out  1  loader accepts a word this cycle.
- im_write_enable  out  1  instruction-memory write strobe.
- im_write_address  out  ADDR_W  instruction-memory write address.
- im_write_data  out  DATA_W  instruction-memory write data.
- core_reset_n  out  1  active-low reset to the CPU core.
- busy  out  1  high in LOAD and HOLD.
- done  out  1  one-cycle pulse on entry to RUN.
- error  out  1  sticky error flag; cleared only by reset or an accepted start.

Behaviour:
- Reset values: state IDLE, host_ready 0, im_write_enable 0, im_write_address 0, im_write_data 0, core_reset_n 0, busy 0, done 0, error 0, counters 0.
- States: IDLE, LOAD, HOLD, RUN.
- IDLE: core held in reset (core_reset_n=0).
  - start with 1 <= word_count <= MEM_WORDS: latch base_addr and word_count, clear error, go to LOAD next cycle.
  - start with word_count==0 or word_count>MEM_WORDS: set error=1, remain in IDLE; no memory write occurs.
- RUN: core_reset_n=1. A valid start behaves as in IDLE and drives core_reset_n=0 from the next cycle. An invalid start sets error and leaves RUN and core_reset_n unchanged.
- LOAD:
  - host_ready=1 combinationally while in LOAD and fewer than word_count words have been accepted.
  - A handshake (host_valid & host_ready) at cycle N registers a write at N+1: im_write_enable=1, im_write_data=host_data, im_write_address=base_addr + k*ADDR_STEP for the k-th word (k from 0).
  - im_write_enable is low in every cycle without a preceding handshake.
  - Back-to-back handshakes sustain one write per cycle.
  - host_valid low inserts bubbles with no timeout.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - On the handshake of word word_count-1, host_ready drops the next cycle and the state goes to HOLD. The final write occurs in the first HOLD cycle (cycle W).
- HOLD: core_reset_n stays 0. core_reset_n goes to 1 first at cycle W+RESET_HOLD; state becomes RUN and done=1 in that same cycle only.
- abort:
  - In LOAD: go to IDLE next cycle, host_ready low next cycle. A write registered from a handshake in the abort cycle is still issued; otherwise no further writes. error is set.
  - In HOLD: go to IDLE, error set, core stays in reset.
  - In IDLE/RUN: ignored.
- start in LOAD or HOLD is ignored. If start and abort are high in the same cycle, abort wins.
- reset mid-operation returns all outputs to reset values on the next edge. Words already written remain in memory; the core stays in reset until a subsequent complete load.
- busy = (state==LOAD || state==HOLD).

Test Plan:
- Basic load: reset, start with base_addr=0x10, word_count=3; stream 0xAAAA0001, 0xAAAA0002, 0xAAAA0003 back-to-back -> writes at 0x10/0x11/0x12 on consecutive cycles; core_reset_n rises 4 cycles after the last write, with done pulsing that cycle.
- Bubbled host: word_count=2, host_valid low for 3 cycles between words -> exactly 2 write strobes at base and base+1; host_ready drops after the second handshake.
- Invalid counts: start with word_count=0, then word_count=MEM_WORDS+1 -> error=1, no im_write_enable, state IDLE, core_reset_n=0; a following valid start clears error.
- Abort: word_count=5, abort after 2 handshakes -> 2 writes, error=1, core_reset_n stays 0, host_ready=0, no done pulse.
- Reload from RUN: after a completed load, start with word_count=1 -> core_reset_n=0 the next cycle; single write; released RESET_HOLD cycles later with done.
- Reset mid-LOAD: assert reset after 1 handshake -> all outputs reset next cycle; no further writes; core_reset_n=0.

Source files
------------

// File: rtl/imem_boot_loader_if.sv
// Host word stream and instruction-memory write port of the boot loader.
// The loader sits on the slave side; the host/memory harness sits on the master side.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              host_valid;
    logic [DATA_W-1:0] host_data;
    logic              host_ready;
    logic              im_write_enable;
    logic [ADDR_W-1:0] im_write_address;
    logic [DATA_W-1:0] im_write_data;

    modport slave (
        input  host_valid, host_data,
        output host_ready, im_write_enable, im_write_address, im_write_data
    );

    modport master (
        output host_valid, host_data,
        input  host_ready, im_write_enable, im_write_address, im_write_data
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a program from a host word stream into instruction memory, then
// releases the core from reset a fixed number of cycles after the last write.
module imem_boot_loader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = 256,
    parameter int ADDR_STEP  = 1,
    parameter int RESET_HOLD = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    imem_boot_loader_if.slave bus,
    output logic              core_reset_n,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int                HOLD_W   = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [ADDR_W-1:0] MAX_WORDS = ADDR_W'(MEM_WORDS);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;    // address of the next word to be written
    logic [ADDR_W-1:0] cnt_q;    // latched word_count
    logic [ADDR_W-1:0] acc_q;    // words accepted so far
    logic [HOLD_W-1:0] hold_q;
    logic              hs, start_ok, start_bad, count_ok;

    assign count_ok          = (word_count != '0) && (word_count <= MAX_WORDS);
    assign bus.host_ready    = (state_q == S_LOAD) && (acc_q < cnt_q);
    assign hs                = bus.host_valid & bus.host_ready;
    assign busy              = (state_q == S_LOAD) || (state_q == S_HOLD);
    assign core_reset_n      = (state_q == S_RUN);

    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (start) begin
                    if (count_ok) begin
                        start_ok = 1'b1;
                        state_d  = S_LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (abort)
                    state_d = S_IDLE;
                else if (hs && (acc_q == cnt_q - ADDR_W'(1)))
                    state_d = S_HOLD;
            end
            S_HOLD: begin
                if (abort)
                    state_d = S_IDLE;
                else if (hold_q == HOLD_LAST)
                    state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q              <= S_IDLE;
            ptr_q                <= '0;
            cnt_q                <= '0;
            acc_q                <= '0;
            hold_q               <= '0;
            done                 <= 1'b0;
            error                <= 1'b0;
            bus.im_write_enable  <= 1'b0;
            bus.im_write_address <= '0;
            bus.im_write_data    <= '0;
        end else begin
            state_q             <= state_d;
            done                <= (state_q == S_HOLD) && (state_d == S_RUN);
            bus.im_write_enable <= hs;
            // A handshake in the abort cycle still lands in memory one cycle later.
            if (hs) begin
                bus.im_write_address <= ptr_q;
                bus.im_write_data    <= bus.host_data;
                ptr_q                <= ptr_q + STEP;
                acc_q                <= acc_q + ADDR_W'(1);
            end
            if (start_ok) begin
                ptr_q <= base_addr;
                cnt_q <= word_count;
                acc_q <= '0;
                error <= 1'b0;
            end
            if (start_bad || (abort && busy))
                error <= 1'b1;
            hold_q <= (state_q == S_HOLD) ? hold_q + HOLD_W'(1) : '0;
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Scenario bench for imem_boot_loader: expected writes are queued when words
// are sent and popped by a write monitor; control outputs checked inline.
module tb_imem_boot_loader;
    localparam int AW = 32, DW = 32, MW = 256, RH = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clock = 0, reset = 1, start = 0, abort = 0;
    logic [AW-1:0] base_addr = '0, word_count = '0;
    logic          core_reset_n, busy, done, error;
    int            checks = 0, failures = 0, writes_seen = 0;
    wr_t           exp_q[$];

    imem_boot_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    imem_boot_loader #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW), .ADDR_STEP(1), .RESET_HOLD(RH)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count), .bus(bus),
        .core_reset_n(core_reset_n), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (bus.im_write_enable === 1'b1) begin
            wr_t e;
            writes_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0h data=%0h", bus.im_write_address, bus.im_write_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.im_write_address !== e.addr || bus.im_write_data !== e.data) begin
                    failures++;
                    $display("FAIL write got addr=%0h data=%0h exp addr=%0h data=%0h",
                             bus.im_write_address, bus.im_write_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
        start = 1; base_addr = b; word_count = n;
        tick();
        start = 0;
    endtask

    // Offer one word and hold it until accepted (bounded wait).
    task automatic send_word(input logic [DW-1:0] d, input logic [AW-1:0] a);
        int n = 0;
        bus.host_valid = 1; bus.host_data = d;
        while (bus.host_ready !== 1'b1 && n < 20) begin tick(); n++; end
        checks++;
        if (bus.host_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_timeout got=%b exp=1", bus.host_ready);
        end else begin
            exp_q.push_back('{addr: a, data: d});
            tick();
        end
        bus.host_valid = 0;
    endtask

    task automatic test_reset();
        reset = 1; tick(); tick();
        checks++;
        if ({bus.host_ready, bus.im_write_enable, core_reset_n, busy, done, error} !== 6'b0 ||
            bus.im_write_address !== '0 || bus.im_write_data !== '0) begin
            failures++;
            $display("FAIL reset_values got=%b exp=000000",
                     {bus.host_ready, bus.im_write_enable, core_reset_n, busy, done, error});
        end
        reset = 0; tick();
    endtask

    // Wait out the hold window after the final write and check release timing.
    task automatic check_release(input string name);
        for (int i = 1; i < RH; i++) begin
            tick();
            checks++;
            if (core_reset_n !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL %s_early_release cyc=%0d got rst_n=%b done=%b exp 0 0", name, i, core_reset_n, done);
            end
        end
        tick();
        checks++;
        if (core_reset_n !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_release got rst_n=%b done=%b busy=%b exp 1 1 0", name, core_reset_n, done, busy);
        end
        tick();
        checks++;
        if (core_reset_n !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse got rst_n=%b done=%b exp 1 0", name, core_reset_n, done);
        end
    endtask

    task automatic test_basic_load();
        do_start(32'h10, 3);
        checks++;
        if (busy !== 1'b1 || bus.host_ready !== 1'b1 || core_reset_n !== 1'b0) begin
            failures++;
            $display("FAIL basic_enter_load got busy=%b ready=%b rst_n=%b exp 1 1 0", busy, bus.host_ready, core_reset_n);
        end
        for (int i = 0; i < 3; i++) begin
            send_word(32'hAAAA0001 + i, 32'h10 + i);
            checks++;
            if (bus.im_write_enable !== 1'b1) begin
                failures++;
                $display("FAIL basic_b2b_write word=%0d got=%b exp=1", i, bus.im_write_enable);
            end
        end
        checks++;
        if (bus.host_ready !== 1'b0 || busy !== 1'b1 || core_reset_n !== 1'b0) begin
            failures++;
            $display("FAIL basic_hold got ready=%b busy=%b rst_n=%b exp 0 1 0", bus.host_ready, busy, core_reset_n);
        end
        check_release("basic");
    endtask

    task automatic test_reload_from_run();
        do_start(32'h20, 1);
        checks++;
        if (core_reset_n !== 1'b0 || busy !== 1'b1 || error !== 1'b0) begin
            failures++;
            $display("FAIL reload_enter got rst_n=%b busy=%b err=%b exp 0 1 0", core_reset_n, busy, error);
        end
        send_word(32'h5A5A1234, 32'h20);
        check_release("reload");
    endtask

    task automatic test_bubbled_host();
        int w0 = writes_seen;
        do_start(32'h40, 2);
        send_word(32'hBEEF0000, 32'h40);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.im_write_enable !== 1'b0 || bus.host_ready !== 1'b1) begin
                failures++;
                $display("FAIL bubble cyc=%0d got we=%b ready=%b exp 0 1", i, bus.im_write_enable, bus.host_ready);
            end
        end
        send_word(32'hBEEF0001, 32'h41);
        checks++;
        if (bus.host_ready !== 1'b0) begin
            failures++;
            $display("FAIL bubble_ready_drop got=%b exp=0", bus.host_ready);
        end
        check_release("bubble");
        checks++;
        if (writes_seen - w0 != 2) begin
            failures++;
            $display("FAIL bubble_write_count got=%0d exp=2", writes_seen - w0);
        end
    endtask

    task automatic test_invalid_counts();
        int w0;
        reset = 1; tick(); reset = 0; tick();
        w0 = writes_seen;
        do_start(32'h0, 0);
        tick();
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || core_reset_n !== 1'b0) begin
            failures++;
            $display("FAIL invalid_zero got err=%b busy=%b rst_n=%b exp 1 0 0", error, busy, core_reset_n);
        end
        do_start(32'h0, MW + 1);
        tick();
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || core_reset_n !== 1'b0 || writes_seen != w0) begin
            failures++;
            $display("FAIL invalid_over got err=%b busy=%b rst_n=%b writes=%0d exp 1 0 0 0",
                     error, busy, core_reset_n, writes_seen - w0);
        end
        // Exactly MEM_WORDS is the largest legal load.
        do_start(32'h0, MW);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1 || bus.host_ready !== 1'b1) begin
            failures++;
            $display("FAIL valid_max_start got err=%b busy=%b ready=%b exp 0 1 1", error, busy, bus.host_ready);
        end
        abort = 1; tick(); abort = 0;
    endtask

    task automatic test_abort();
        int w0;
        reset = 1; tick(); reset = 0; tick();
        w0 = writes_seen;
        do_start(32'h80, 5);
        send_word(32'hC0DE0000, 32'h80);
        send_word(32'hC0DE0001, 32'h81);
        abort = 1; tick(); abort = 0;
        checks++;
        if (bus.host_ready !== 1'b0 || busy !== 1'b0 || error !== 1'b1 || core_reset_n !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got ready=%b busy=%b err=%b rst_n=%b exp 0 0 1 0",
                     bus.host_ready, busy, error, core_reset_n);
        end
        for (int i = 0; i < RH + 2; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || core_reset_n !== 1'b0) begin
                failures++;
                $display("FAIL abort_no_done cyc=%0d got done=%b rst_n=%b exp 0 0", i, done, core_reset_n);
            end
        end
        checks++;
        if (writes_seen - w0 != 2) begin
            failures++;
            $display("FAIL abort_write_count got=%0d exp=2", writes_seen - w0);
        end
    endtask

    task automatic test_reset_mid_load();
        int w0 = writes_seen;
        do_start(32'hF0, 4);
        send_word(32'h0BAD0001, 32'hF0);
        reset = 1; tick();
        checks++;
        if ({bus.host_ready, bus.im_write_enable, core_reset_n, busy, done, error} !== 6'b0 ||
            bus.im_write_address !== '0 || bus.im_write_data !== '0) begin
            failures++;
            $display("FAIL mid_reset got=%b addr=%0h data=%0h exp all 0",
                     {bus.host_ready, bus.im_write_enable, core_reset_n, busy, done, error},
                     bus.im_write_address, bus.im_write_data);
        end
        reset = 0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (writes_seen - w0 != 1 || core_reset_n !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_after got writes=%0d rst_n=%b busy=%b exp 1 0 0", writes_seen - w0, core_reset_n, busy);
        end
    endtask

    initial begin
        bus.host_valid = 0;
        bus.host_data  = '0;
        test_reset();
        test_basic_load();
        test_reload_from_run();
        test_bubbled_host();
        test_invalid_counts();
        test_abort();
        test_reset_mid_load();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
